// File: rtl/tetris_pkg.sv
// Shared types and defaults for the active-piece mover: FSM states, command
// codes, board limits and the 10-bit position record.
package tetris_pkg;

   localparam int COL_MAX_DEF = 19;
   localparam int ROW_MAX_DEF = 29;
   localparam int SPAWN_X_DEF = 9;
   localparam int ROT_N       = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHECK     = 3'd1,
      ST_COMMIT    = 3'd2,
      ST_LOCK      = 3'd3,
      ST_SPAWN_CHK = 3'd4,
      ST_DEAD      = 3'd5,
      ST_DROP      = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CMD_GRAV  = 3'd0,
      CMD_DOWN  = 3'd1,
      CMD_ROT   = 3'd2,
      CMD_LEFT  = 3'd3,
      CMD_RIGHT = 3'd4,
      CMD_DROP  = 3'd5
   } cmd_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] rot;
   } pos_t;

   // Quarter-turn step; anything at or past the last orientation wraps to 0.
   function automatic logic [9:0] rot_inc(input logic [9:0] r);
      return (r >= 10'(ROT_N - 1)) ? 10'd0 : r + 10'd1;
   endfunction

endpackage

// File: rtl/block_mover_gravity_timer.sv
// Free-running gravity divider: counts 0..DIV-1 while enabled and pulses tick
// on the cycle the count wraps.
module gravity_timer #(
   parameter int DIV = 25000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/block_mover.sv
// Writer side of the active-piece position register: arbitrates commands and
// gravity, qualifies moves with the collision checker, commits or locks.
// Optional hard drop (btn_drop + DROP loop) enabled by BLOCK_MOVER_HARD_DROP_EN.
module block_mover
   import tetris_pkg::*;
#(
   parameter int GRAVITY_DIV = 25000000,
   parameter int COL_MAX     = COL_MAX_DEF,
   parameter int ROW_MAX     = ROW_MAX_DEF,
   parameter int SPAWN_X     = SPAWN_X_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_down,
   input  logic       btn_rot,
`ifdef BLOCK_MOVER_HARD_DROP_EN
   input  logic       btn_drop,
`endif
   input  logic [9:0] block_pos_x_cur,
   input  logic [9:0] block_pos_y_cur,
   input  logic [9:0] rotate_cur,
   output logic       chk_req,
   output logic [9:0] chk_x,
   output logic [9:0] chk_y,
   output logic [9:0] chk_rot,
   input  logic       chk_ack,
   input  logic       chk_hit,
   output logic [9:0] block_pos_x_next,
   output logic [9:0] block_pos_y_next,
   output logic [9:0] rotate_next,
   output logic       lock,
   output logic       game_over
);

   localparam logic [9:0] COL_MAX_W = 10'(COL_MAX);
   localparam logic [9:0] ROW_MAX_W = 10'(ROW_MAX);
   localparam logic [9:0] SPAWN_X_W = 10'(SPAWN_X);

   state_t     state, state_n;
   pos_t       cand, cand_n, cur;
   logic       cand_down, cand_down_n;
   logic       drop_act, drop_act_n;
   logic       game_over_n;
   logic [5:0] pend, pend_n, pulse, eff, clr;
   logic       tick;

   assign cur = '{x: block_pos_x_cur, y: block_pos_y_cur, rot: rotate_cur};

   gravity_timer #(.DIV(GRAVITY_DIV)) u_grav (
      .clk  (clk),
      .rst  (rst),
      .en   (!game_over),
      .tick (tick)
   );

   always_comb begin
      pulse            = '0;
      pulse[CMD_GRAV]  = tick;
      pulse[CMD_DOWN]  = btn_down;
      pulse[CMD_ROT]   = btn_rot;
      pulse[CMD_LEFT]  = btn_left;
      pulse[CMD_RIGHT] = btn_right;
`ifdef BLOCK_MOVER_HARD_DROP_EN
      pulse[CMD_DROP]  = btn_drop;
`endif
   end

   // Same-cycle pulses are visible to dispatch so IDLE answers in one cycle.
   assign eff = pend | pulse;

   always_comb begin
      state_n     = state;
      cand_n      = cand;
      cand_down_n = cand_down;
      drop_act_n  = drop_act;
      game_over_n = game_over;
      clr         = '0;
      pend_n      = '0;
      case (state)
         ST_IDLE: begin
            if (eff[CMD_DROP]) begin
               clr[CMD_DROP] = 1'b1;
               drop_act_n    = 1'b1;
               if (cur.y >= ROW_MAX_W) begin
                  state_n = ST_LOCK;
               end else begin
                  cand_n      = '{x: cur.x, y: cur.y + 10'd1, rot: cur.rot};
                  cand_down_n = 1'b1;
                  state_n     = ST_CHECK;
               end
            end else if (eff[CMD_GRAV] || eff[CMD_DOWN]) begin
               clr[CMD_GRAV] = 1'b1;
               clr[CMD_DOWN] = 1'b1;
               if (cur.y >= ROW_MAX_W) begin
                  state_n = ST_LOCK;
               end else begin
                  cand_n      = '{x: cur.x, y: cur.y + 10'd1, rot: cur.rot};
                  cand_down_n = 1'b1;
                  state_n     = ST_CHECK;
               end
            end else if (eff[CMD_ROT]) begin
               clr[CMD_ROT] = 1'b1;
               cand_n       = '{x: cur.x, y: cur.y, rot: rot_inc(cur.rot)};
               cand_down_n  = 1'b0;
               state_n      = ST_CHECK;
            end else if (eff[CMD_LEFT]) begin
               clr[CMD_LEFT] = 1'b1;
               if (cur.x != 10'd0) begin
                  cand_n      = '{x: cur.x - 10'd1, y: cur.y, rot: cur.rot};
                  cand_down_n = 1'b0;
                  state_n     = ST_CHECK;
               end
            end else if (eff[CMD_RIGHT]) begin
               clr[CMD_RIGHT] = 1'b1;
               if (cur.x < COL_MAX_W) begin
                  cand_n      = '{x: cur.x + 10'd1, y: cur.y, rot: cur.rot};
                  cand_down_n = 1'b0;
                  state_n     = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (chk_ack) begin
               if (!chk_hit)      state_n = ST_COMMIT;
               else if (cand_down) state_n = ST_LOCK;
               else               state_n = ST_IDLE;
            end
         end
         ST_COMMIT: begin
`ifdef BLOCK_MOVER_HARD_DROP_EN
            state_n = drop_act ? ST_DROP : ST_IDLE;
`else
            state_n = ST_IDLE;
`endif
         end
`ifdef BLOCK_MOVER_HARD_DROP_EN
         ST_DROP: begin
            // cur already reflects the move committed in the previous cycle.
            if (cur.y >= ROW_MAX_W) begin
               state_n = ST_LOCK;
            end else begin
               cand_n      = '{x: cur.x, y: cur.y + 10'd1, rot: cur.rot};
               cand_down_n = 1'b1;
               state_n     = ST_CHECK;
            end
         end
`endif
         ST_LOCK: begin
            cand_n      = '{x: SPAWN_X_W, y: 10'd0, rot: 10'd0};
            cand_down_n = 1'b0;
            drop_act_n  = 1'b0;
            state_n     = ST_SPAWN_CHK;
         end
         ST_SPAWN_CHK: begin
            if (chk_ack) begin
               if (chk_hit) begin
                  game_over_n = 1'b1;
                  state_n     = ST_DEAD;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_DEAD: state_n = ST_DEAD;
         default: state_n = ST_IDLE;
      endcase

      if (state != ST_LOCK && state != ST_DEAD)
         pend_n = eff & ~clr;
      if (drop_act_n)
         pend_n[CMD_GRAV] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cand      <= '0;
         cand_down <= 1'b0;
         drop_act  <= 1'b0;
         pend      <= '0;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         cand_down <= cand_down_n;
         drop_act  <= drop_act_n;
         pend      <= pend_n;
         game_over <= game_over_n;
      end
   end

   assign chk_req = (state == ST_CHECK) || (state == ST_SPAWN_CHK);
   assign chk_x   = cand.x;
   assign chk_y   = cand.y;
   assign chk_rot = cand.rot;
   assign lock    = (state == ST_LOCK);

   assign block_pos_x_next = (state == ST_COMMIT) ? cand.x   : cur.x;
   assign block_pos_y_next = (state == ST_COMMIT) ? cand.y   : cur.y;
   assign rotate_next      = (state == ST_COMMIT) ? cand.rot : cur.rot;

endmodule

// File: tb/tb_block_mover.sv
// Directed bench for block_mover: table of single-move transactions plus
// hand-written sequences for gravity/game-over, queued commands and async reset.
module tb_block_mover;

   localparam int GDIV = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rot = 1'b0;
`ifdef BLOCK_MOVER_HARD_DROP_EN
   logic       btn_drop = 1'b0;
`endif
   logic [9:0] x_cur = '0, y_cur = '0, r_cur = '0;
   logic       chk_req, chk_ack = 1'b0, chk_hit = 1'b0;
   logic [9:0] chk_x, chk_y, chk_rot;
   logic [9:0] x_next, y_next, r_next;
   logic       lock, game_over;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   block_mover #(.GRAVITY_DIV(GDIV), .COL_MAX(19), .ROW_MAX(29), .SPAWN_X(9)) dut (
      .clk              (clk),
      .rst              (rst),
      .btn_left         (btn_left),
      .btn_right        (btn_right),
      .btn_down         (btn_down),
      .btn_rot          (btn_rot),
`ifdef BLOCK_MOVER_HARD_DROP_EN
      .btn_drop         (btn_drop),
`endif
      .block_pos_x_cur  (x_cur),
      .block_pos_y_cur  (y_cur),
      .rotate_cur       (r_cur),
      .chk_req          (chk_req),
      .chk_x            (chk_x),
      .chk_y            (chk_y),
      .chk_rot          (chk_rot),
      .chk_ack          (chk_ack),
      .chk_hit          (chk_hit),
      .block_pos_x_next (x_next),
      .block_pos_y_next (y_next),
      .rotate_next      (r_next),
      .lock             (lock),
      .game_over        (game_over)
   );

   localparam int C_LEFT = 0, C_RIGHT = 1, C_DOWN = 2, C_ROT = 3;
   localparam int O_NOREQ = 0, O_COMMIT = 1, O_REJECT = 2, O_LOCK = 3, O_LOCKD = 4;

   typedef struct {
      logic [9:0] x, y, r;
      int         cmd;
      bit         hit;
      int         outc;
      logic [9:0] ex, ey, er;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      btn_left = 0; btn_right = 0; btn_down = 0; btn_rot = 0;
      chk_ack = 0; chk_hit = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic press(input int cmd);
      btn_left  = (cmd == C_LEFT);
      btn_right = (cmd == C_RIGHT);
      btn_down  = (cmd == C_DOWN);
      btn_rot   = (cmd == C_ROT);
      @(negedge clk);
      btn_left = 0; btn_right = 0; btn_down = 0; btn_rot = 0;
   endtask

   task automatic ack(input bit h);
      chk_ack = 1; chk_hit = h;
      @(negedge clk);
      chk_ack = 0; chk_hit = 0;
   endtask

   task automatic wait_req(input string name);
      bit ok = 0;
      for (int i = 0; i < 8; i++) begin
         if (chk_req) begin ok = 1; break; end
         @(negedge clk);
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string n;
      n = $sformatf("v%0d", idx);
      do_reset();
      x_cur = v.x; y_cur = v.y; r_cur = v.r;
      press(v.cmd);
      case (v.outc)
         O_NOREQ: begin
            int seen = 0;
            for (int i = 0; i < 5; i++) begin
               if (chk_req) seen++;
               @(negedge clk);
            end
            check({n, "_noreq"}, 32'(seen), 32'd0);
            check({n, "_mirror"}, {2'b0, x_next, y_next, r_next}, {2'b0, v.x, v.y, v.r});
         end
         O_LOCKD: begin
            check({n, "_lock"}, {31'b0, lock}, 32'd1);
            check({n, "_noreq"}, {31'b0, chk_req}, 32'd0);
            @(negedge clk);
            check({n, "_spawn"}, {1'b0, chk_req, x_next == v.x ? 1'b0 : 1'b1, lock, chk_x, chk_y, chk_rot[7:0]},
                  {1'b0, 1'b1, 1'b0, 1'b0, 10'd9, 10'd0, 8'd0});
            ack(0);
            check({n, "_idle"}, {30'b0, chk_req, game_over}, 32'd0);
         end
         default: begin
            check({n, "_req"}, {31'b0, chk_req}, 32'd1);
            check({n, "_cand"}, {2'b0, chk_x, chk_y, chk_rot}, {2'b0, v.ex, v.ey, v.er});
            ack(v.hit);
            if (v.outc == O_COMMIT) begin
               check({n, "_next"}, {1'b0, lock, x_next, y_next, r_next}, {2'b0, v.ex, v.ey, v.er});
               @(negedge clk);
               check({n, "_hold"}, {1'b0, chk_req, x_next, y_next, r_next}, {2'b0, v.x, v.y, v.r});
            end else if (v.outc == O_REJECT) begin
               check({n, "_rej"}, {lock, chk_req, x_next, y_next, r_next}, {2'b0, v.x, v.y, v.r});
            end else begin
               check({n, "_lock"}, {1'b0, lock, x_next, y_next, r_next}, {2'b1, v.x, v.y, v.r});
               @(negedge clk);
               check({n, "_spawn"}, {lock, chk_req, chk_x, chk_y, chk_rot}, {2'b01, 10'd9, 10'd0, 10'd0});
               ack(0);
               check({n, "_alive"}, {30'b0, chk_req, game_over}, 32'd0);
            end
         end
      endcase
   endtask

   initial begin
      vecs[0]  = '{10'd9,  10'd0,  10'd0, C_LEFT,  1'b0, O_COMMIT, 10'd8,  10'd0,  10'd0};
      vecs[1]  = '{10'd0,  10'd5,  10'd1, C_LEFT,  1'b0, O_NOREQ,  10'd0,  10'd0,  10'd0};
      vecs[2]  = '{10'd19, 10'd5,  10'd1, C_RIGHT, 1'b0, O_NOREQ,  10'd0,  10'd0,  10'd0};
      vecs[3]  = '{10'd18, 10'd5,  10'd1, C_RIGHT, 1'b0, O_COMMIT, 10'd19, 10'd5,  10'd1};
      vecs[4]  = '{10'd4,  10'd7,  10'd3, C_ROT,   1'b0, O_COMMIT, 10'd4,  10'd7,  10'd0};
      vecs[5]  = '{10'd4,  10'd7,  10'd1, C_ROT,   1'b0, O_COMMIT, 10'd4,  10'd7,  10'd2};
      vecs[6]  = '{10'd4,  10'd7,  10'd2, C_DOWN,  1'b0, O_COMMIT, 10'd4,  10'd8,  10'd2};
      vecs[7]  = '{10'd4,  10'd29, 10'd2, C_DOWN,  1'b0, O_LOCKD,  10'd0,  10'd0,  10'd0};
      vecs[8]  = '{10'd4,  10'd7,  10'd2, C_DOWN,  1'b1, O_LOCK,   10'd4,  10'd8,  10'd2};
      vecs[9]  = '{10'd10, 10'd3,  10'd0, C_LEFT,  1'b1, O_REJECT, 10'd9,  10'd3,  10'd0};
      vecs[10] = '{10'd5,  10'd5,  10'd0, C_RIGHT, 1'b1, O_REJECT, 10'd6,  10'd5,  10'd0};

      // Reset state, with next outputs mirroring cur.
      x_cur = 10'd7; y_cur = 10'd3; r_cur = 10'd2;
      #12;
      check("rst_ctrl", {29'b0, chk_req, lock, game_over}, 32'd0);
      check("rst_cand", {2'b0, chk_x, chk_y, chk_rot}, 32'd0);
      check("rst_mirror", {2'b0, x_next, y_next, r_next}, {2'b0, 10'd7, 10'd3, 10'd2});

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Gravity tick -> hit -> lock -> blocked spawn -> game over.
      begin
         int lat = 0;
         int bad = 0;
         do_reset();
         x_cur = 10'd3; y_cur = 10'd5; r_cur = 10'd0;
         for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (chk_req) begin lat = i; break; end
         end
         check("grav_latency", 32'(lat), 32'(GDIV));
         check("grav_cand", {2'b0, chk_x, chk_y, chk_rot}, {2'b0, 10'd3, 10'd6, 10'd0});
         ack(1);
         check("grav_lock", {31'b0, lock}, 32'd1);
         @(negedge clk);
         check("grav_lock_1cyc", {lock, chk_req, chk_x, chk_y, chk_rot}, {2'b01, 10'd9, 10'd0, 10'd0});
         ack(1);
         check("game_over_set", {30'b0, game_over, chk_req}, 32'd2);
         press(C_LEFT);
         press(C_ROT);
         press(C_DOWN);
         for (int i = 0; i < 2 * GDIV; i++) begin
            if (chk_req || lock || !game_over) bad++;
            @(negedge clk);
         end
         check("dead_absorbing", 32'(bad), 32'd0);
      end

      // Commands queued during a slow CHECK: left before right, both serviced.
      begin
         int extra = 0;
         do_reset();
         x_cur = 10'd9; y_cur = 10'd0; r_cur = 10'd0;
         press(C_DOWN);
         check("q_req", {31'b0, chk_req}, 32'd1);
         press(C_LEFT);
         press(C_RIGHT);
         ack(0);
         check("q_down_commit", {22'b0, y_next}, 32'd1);
         @(negedge clk);
         wait_req("q_left_req");
         check("q_left_first", {22'b0, chk_x}, 32'd8);
         ack(0);
         check("q_left_commit", {22'b0, x_next}, 32'd8);
         @(negedge clk);
         wait_req("q_right_req");
         check("q_right_second", {22'b0, chk_x}, 32'd10);
         ack(0);
         check("q_right_commit", {22'b0, x_next}, 32'd10);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (chk_req) extra++;
         end
         check("q_drained", 32'(extra), 32'd0);
      end

      // Async reset in the middle of CHECK; stray ack in IDLE is ignored.
      begin
         int bad = 0;
         do_reset();
         x_cur = 10'd9; y_cur = 10'd0; r_cur = 10'd0;
         press(C_LEFT);
         check("ar_req", {31'b0, chk_req}, 32'd1);
         #2 rst = 1;
         #1;
         check("ar_async_drop", {22'b0, chk_req, chk_x[8:0]}, 32'd0);
         @(negedge clk);
         rst = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lock || chk_req || game_over) bad++;
         end
         check("ar_quiet", 32'(bad), 32'd0);
         ack(0);
         check("ar_stray_ack", {1'b0, chk_req, x_next, y_next, r_next}, {2'b0, 10'd9, 10'd0, 10'd0});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
